calc_req_scheduler: RTL
=======================

Name: calc_req_scheduler

Overview:
- Shares the single calculator command port (cmd/data/tag in; resp/data/tag out) among NUM_REQ requesters.
- Round-robin arbitration; allocates a free tag per command; drives the two-cycle operand transfer.
- Tracks tag ownership and routes each tagged response back to the requester that issued it.
- Sits between the stimulus or host side and the calculator DUT ports.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- CMD_WIDTH, 4, command field width (shared package constant)
- DATA_WIDTH, 32, operand/result width (shared package constant)
- TAG_WIDTH, 2, tag width; tag pool size NUM_TAGS = 2**TAG_WIDTH
- RESP_WIDTH, 2, response code width (0 none, 1 success, 2 overflow/underflow, 3 invalid cmd)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  requester i offers a command
- req_ready  out  NUM_REQ  requester i command accepted this cycle (valid&ready)
- req_cmd  in  NUM_REQ*CMD_WIDTH  flattened commands, requester i at slice i
- req_op1  in  NUM_REQ*DATA_WIDTH  flattened first operands
- req_op2  in  NUM_REQ*DATA_WIDTH  flattened second operands
- rsp_valid  out  NUM_REQ  one-hot pulse: response for requester i
- rsp_resp  out  RESP_WIDTH  response code, shared bus
- rsp_data  out  DATA_WIDTH  result, shared bus
- cmd_in  out  CMD_WIDTH  to calculator
- data_in  out  DATA_WIDTH  to calculator
- tag_in  out  TAG_WIDTH  to calculator
- out_resp  in  RESP_WIDTH  from calculator
- out_data  in  DATA_WIDTH  from calculator
- out_tag  in  TAG_WIDTH  from calculator
- busy  out  1  any tag outstanding or issue in progress
- stray_rsp  out  1  one-cycle pulse: response arrived on an unallocated tag

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high on reset. All outputs are registered except req_ready, which is combinational from state, tag pool and req_valid.
- Reset values: all outputs 0. Tag pool all free; owner table cleared; FSM IDLE; RR pointer = NUM_REQ-1, so requester 0 has first priority.
- FSM states:
  - IDLE: accept allowed.
  - OP1: drives cmd_in = cmd, data_in = op1, tag_in = tag. Always goes to OP2.
  - OP2: drives cmd_in = 0, data_in = op2, tag_in = tag. Accept allowed; goes to OP1 on accept, otherwise IDLE.
- Accept condition: state is IDLE or OP2, at least one req_valid, and at least one tag free at the start of the cycle.
- Grant: first valid requester searching from RR pointer+1 with wrap. req_ready is asserted only for the granted requester. On accept, the pointer updates to the grantee.
- Capture on accept: cmd, op1, op2 and grantee index are latched. The tag is the lowest-index free tag; it is marked busy and owner[tag] = grantee.
- Issue latency: accept in cycle N gives OP1 values on the pins in N+1 and OP2 values in N+2. Back-to-back throughput is one command per 2 cycles.
- Idle pins: in IDLE, cmd_in, data_in and tag_in are 0.
- Response handling: out_resp != 0 in cycle M with tag T allocated gives, in cycle M+1:
  - rsp_valid[owner[T]] = 1, rsp_resp = out_resp, rsp_data = out_data;
  - tag T freed, available to the accept decision from M+1.
- Stray response: out_resp != 0 on a free tag gives stray_rsp = 1 at M+1. No rsp_valid is raised and pool state is unchanged.
- Simultaneous free and allocate: a tag freed by a response in cycle M is not usable by an accept in cycle M; it becomes usable from M+1.
- Pool full: all NUM_TAGS outstanding holds req_ready at 0. Requesters hold valid; there is no drop.
- Ordering: a requester may hold several outstanding tags. Responses may return out of order and are routed by tag only.
- Command contents: commands are not checked; an invalid cmd is issued as-is and the calculator's code-3 response is routed normally.
- busy = (any tag allocated) | (state != IDLE), registered.
- Reset mid-operation: the transfer in progress is abandoned. The pool and owner table are cleared. Late responses after reset report as stray.

Decomposition:
- Shared package (with the existing definitions): CMD_WIDTH, DATA_WIDTH, TAG_WIDTH, RESP_WIDTH, command encodings (NOP=0, ADD=1, SUB=2, SHL=5, SHR=6), response codes, and a scheduler state enum {IDLE, OP1, OP2}.
- One sub-module: calc_rr_arbiter. Inputs are the request vector, pointer and enable; outputs are a one-hot grant and its index. Pure combinational search, instantiated once.

Test Plan:
- Single issue: req0 ADD op1=5 op2=7 accepted cycle N.
  - Pins at N+1: cmd=1 data=5 tag=0. At N+2: cmd=0 data=7.
  - Calculator returns resp=1 data=12 tag=0, giving rsp_valid=0001, rsp_data=12; tag 0 freed.
- Four simultaneous requesters with all valid from reset: grant order 0,1,2,3; tags 0,1,2,3; accepts at cycles N, N+2, N+4, N+6.
- Pool full: a fifth valid (req0 again) sees req_ready=0 until a response arrives.
  - Response tag 2 at M gives rsp_valid=0100 at M+1; req0 is accepted at M+1 with tag 2.
- Out of order: tags 3,0,2,1 return in that order with distinct data. Each result goes to its owner; busy falls the cycle after the last response.
- Stray: out_resp=1 with tag 1 while it is free gives stray_rsp pulse, no rsp_valid, pool unchanged.
- Reset mid-operation: reset asserted in OP1 with 2 tags outstanding.
  - Next cycle: all outputs 0, busy=0, RR restarts at req0.
  - A subsequent response on an old tag pulses stray_rsp.

Source files
------------

// File: rtl/calc_req_scheduler_pkg.sv
// Purpose: shared widths, command/response encodings and scheduler state for the calculator port.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package calc_req_scheduler_pkg;

    localparam int CMD_WIDTH  = 4;
    localparam int DATA_WIDTH = 32;
    localparam int TAG_WIDTH  = 2;
    localparam int RESP_WIDTH = 2;
    localparam int NUM_TAGS   = 2 ** TAG_WIDTH;

    localparam logic [CMD_WIDTH-1:0] CMD_NOP = 4'd0;
    localparam logic [CMD_WIDTH-1:0] CMD_ADD = 4'd1;
    localparam logic [CMD_WIDTH-1:0] CMD_SUB = 4'd2;
    localparam logic [CMD_WIDTH-1:0] CMD_SHL = 4'd5;
    localparam logic [CMD_WIDTH-1:0] CMD_SHR = 4'd6;

    localparam logic [RESP_WIDTH-1:0] RESP_NONE     = 2'd0;
    localparam logic [RESP_WIDTH-1:0] RESP_SUCCESS  = 2'd1;
    localparam logic [RESP_WIDTH-1:0] RESP_OVERFLOW = 2'd2;
    localparam logic [RESP_WIDTH-1:0] RESP_INVALID  = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OP1  = 2'd1,
        OP2  = 2'd2
    } sched_state_e;

endpackage

// File: rtl/calc_rr_arbiter.sv
// Purpose: round-robin pick of the first set request after ptr (with wrap); one-hot grant + index.
// Latency: purely combinational.
// Backpressure: en=0 forces an empty grant.
// Ports: req (request vector), ptr (last grantee), en (grant allowed) -> gnt (one-hot), gnt_idx.
module calc_rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);

    int   cand;
    logic found;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        cand    = 0;
        // Search starts one past the last grantee so it drops to lowest priority.
        for (int off = 1; off <= N; off++) begin
            cand = (int'(ptr) + off) % N;
            if (en && !found && req[cand]) begin
                found        = 1'b1;
                gnt[cand]    = 1'b1;
                gnt_idx      = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/calc_req_scheduler.sv
// Purpose: shares one tagged calculator command port among NUM_REQ requesters; routes responses by tag.
// Latency: accept in N -> cmd/op1 on pins at N+1, op2 at N+2; response at M -> rsp_valid at M+1.
// Backpressure: req_ready held low while issuing op1 or while every tag is outstanding; requesters hold valid.
// Ports: req_* (requester side, flattened per index), cmd_in/data_in/tag_in (to calculator),
//        out_* (from calculator), rsp_* (routed response), busy, stray_rsp.
module calc_req_scheduler
    import calc_req_scheduler_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*CMD_WIDTH-1:0]  req_cmd,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_op1,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_op2,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [RESP_WIDTH-1:0]         rsp_resp,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic [CMD_WIDTH-1:0]          cmd_in,
    output logic [DATA_WIDTH-1:0]         data_in,
    output logic [TAG_WIDTH-1:0]          tag_in,
    input  logic [RESP_WIDTH-1:0]         out_resp,
    input  logic [DATA_WIDTH-1:0]         out_data,
    input  logic [TAG_WIDTH-1:0]          out_tag,
    output logic                          busy,
    output logic                          stray_rsp
);

    localparam int IW = $clog2(NUM_REQ);

    sched_state_e            state_q, state_d;
    logic [IW-1:0]           rr_ptr_q, rr_ptr_d;
    logic [NUM_TAGS-1:0]     tag_busy_q, tag_busy_d;
    logic [IW-1:0]           owner_q [NUM_TAGS];
    logic [IW-1:0]           owner_d [NUM_TAGS];
    logic [DATA_WIDTH-1:0]   cur_op2_q, cur_op2_d;
    logic [TAG_WIDTH-1:0]    cur_tag_q, cur_tag_d;
    logic [CMD_WIDTH-1:0]    cmd_in_q, cmd_in_d;
    logic [DATA_WIDTH-1:0]   data_in_q, data_in_d;
    logic [TAG_WIDTH-1:0]    tag_in_q, tag_in_d;
    logic [NUM_REQ-1:0]      rsp_valid_q, rsp_valid_d;
    logic [RESP_WIDTH-1:0]   rsp_resp_q, rsp_resp_d;
    logic [DATA_WIDTH-1:0]   rsp_data_q, rsp_data_d;
    logic                    busy_q, busy_d;
    logic                    stray_q, stray_d;

    logic                    pool_has_free;
    logic [TAG_WIDTH-1:0]    free_tag;
    logic                    accept_ok;
    logic                    accept;
    logic [NUM_REQ-1:0]      gnt;
    logic [IW-1:0]           gnt_idx;

    // Lowest-index free tag, from the pool as it stood at the start of the cycle:
    // a tag freed by this cycle's response only becomes usable next cycle.
    always_comb begin
        pool_has_free = 1'b0;
        free_tag      = '0;
        for (int t = NUM_TAGS - 1; t >= 0; t--) begin
            if (!tag_busy_q[t]) begin
                pool_has_free = 1'b1;
                free_tag      = TAG_WIDTH'(t);
            end
        end
    end

    assign accept_ok = ((state_q == IDLE) || (state_q == OP2)) && pool_has_free;

    calc_rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_arb (
        .req     (req_valid),
        .ptr     (rr_ptr_q),
        .en      (accept_ok),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign accept    = |gnt;
    assign req_ready = gnt;

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        tag_busy_d  = tag_busy_q;
        owner_d     = owner_q;
        cur_op2_d   = cur_op2_q;
        cur_tag_d   = cur_tag_q;
        cmd_in_d    = '0;
        data_in_d   = '0;
        tag_in_d    = '0;
        rsp_valid_d = '0;
        rsp_resp_d  = '0;
        rsp_data_d  = '0;
        stray_d     = 1'b0;

        case (state_q)
            IDLE:    state_d = accept ? OP1 : IDLE;
            OP1:     state_d = OP2;
            OP2:     state_d = accept ? OP1 : IDLE;
            default: state_d = IDLE;
        endcase

        // Pin registers load the values of the state being entered, so OP1
        // values appear exactly one cycle after the accept.
        if (accept) begin
            rr_ptr_d           = gnt_idx;
            tag_busy_d[free_tag] = 1'b1;
            owner_d[free_tag]  = gnt_idx;
            cur_op2_d          = req_op2[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
            cur_tag_d          = free_tag;
            cmd_in_d           = req_cmd[gnt_idx*CMD_WIDTH +: CMD_WIDTH];
            data_in_d          = req_op1[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
            tag_in_d           = free_tag;
        end else if (state_q == OP1) begin
            data_in_d = cur_op2_q;
            tag_in_d  = cur_tag_q;
        end

        // A response can only hit an allocated tag, never the free one being
        // allocated above, so the two pool updates never collide.
        if (out_resp != RESP_NONE) begin
            if (tag_busy_q[out_tag]) begin
                rsp_valid_d[owner_q[out_tag]] = 1'b1;
                rsp_resp_d                    = out_resp;
                rsp_data_d                    = out_data;
                tag_busy_d[out_tag]           = 1'b0;
            end else begin
                stray_d = 1'b1;
            end
        end

        busy_d = (|tag_busy_d) || (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            rr_ptr_q    <= IW'(NUM_REQ - 1);
            tag_busy_q  <= '0;
            for (int t = 0; t < NUM_TAGS; t++) owner_q[t] <= '0;
            cur_op2_q   <= '0;
            cur_tag_q   <= '0;
            cmd_in_q    <= '0;
            data_in_q   <= '0;
            tag_in_q    <= '0;
            rsp_valid_q <= '0;
            rsp_resp_q  <= '0;
            rsp_data_q  <= '0;
            busy_q      <= 1'b0;
            stray_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            tag_busy_q  <= tag_busy_d;
            owner_q     <= owner_d;
            cur_op2_q   <= cur_op2_d;
            cur_tag_q   <= cur_tag_d;
            cmd_in_q    <= cmd_in_d;
            data_in_q   <= data_in_d;
            tag_in_q    <= tag_in_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_resp_q  <= rsp_resp_d;
            rsp_data_q  <= rsp_data_d;
            busy_q      <= busy_d;
            stray_q     <= stray_d;
        end
    end

    assign cmd_in    = cmd_in_q;
    assign data_in   = data_in_q;
    assign tag_in    = tag_in_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_resp  = rsp_resp_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = busy_q;
    assign stray_rsp = stray_q;

endmodule
